// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the MAC scheduler and its arbiter.
package mac_sched_pkg;

  localparam int DATA_W  = 8;
  localparam int MAC_OPS = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_SEND_C = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
  } mac_ops_t;

  // Width of an index or counter that must hold values 0..n-1 (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// wrapping to the lowest requesting index below ptr.
module rr_arbiter
  import mac_sched_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic found;

  // Two passes: upper segment [ptr..N_REQ-1] has priority over the wrapped [0..ptr-1].
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
    any = found;
  end

endmodule

// File: rtl/mac_scheduler.sv
// Shares one a*b+c datapath between N_REQ requesters: round-robin grant,
// three-cycle operand stream, wait for the result (or time out), respond to owner.
module mac_scheduler
  import mac_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*DATA_W-1:0] req_c,
  output logic [N_REQ-1:0]        gnt,
  output logic                    validi,
  output logic [DATA_W-1:0]       data_in,
  input  logic                    valido,
  input  logic [DATA_W-1:0]       data_out,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    spurious
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = idx_width(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  mac_ops_t          ops_q, ops_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              validi_q, validi_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              spurious_q, spurious_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  mac_ops_t          sel_ops;
  logic [N_REQ-1:0]  owner_onehot;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign owner_onehot = N_REQ'(1) << owner_q;

  // Operand triple of the requester the arbiter is currently picking.
  always_comb begin
    sel_ops = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_ops.a = req_a[i*DATA_W +: DATA_W];
        sel_ops.b = req_b[i*DATA_W +: DATA_W];
        sel_ops.c = req_c[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next registered outputs; outputs default to idle-low each cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    ops_d       = ops_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    validi_d    = 1'b0;
    data_in_d   = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    // A result strobe is only meaningful while waiting for one.
    spurious_d  = valido && (state_q != ST_WAIT);

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          owner_d   = arb_idx;
          ops_d     = sel_ops;
          gnt_d     = arb_gnt;
          ptr_d     = (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);
          // Operand a goes out in the same cycle as the grant.
          validi_d  = 1'b1;
          data_in_d = sel_ops.a;
          state_d   = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        validi_d  = 1'b1;
        data_in_d = ops_q.b;
        state_d   = ST_SEND_B;
      end
      ST_SEND_B: begin
        validi_d  = 1'b1;
        data_in_d = ops_q.c;
        state_d   = ST_SEND_C;
      end
      ST_SEND_C: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (valido) begin
          rsp_valid_d = owner_onehot;
          rsp_data_d  = data_out;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = owner_onehot;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and every visible output; reset aborts any operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      validi_q    <= 1'b0;
      data_in_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      validi_q    <= validi_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      spurious_q  <= spurious_d;
    end
  end

  // Operand latch, owner and wait counter; only read in states that loaded them first.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    ops_q   <= ops_d;
    cnt_q   <= cnt_d;
  end

  assign gnt       = gnt_q;
  assign validi    = validi_q;
  assign data_in   = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign spurious  = spurious_q;

endmodule

// File: tb/tb_mac_scheduler.sv
// Bench for mac_scheduler: transaction-level reference model plus a MAC datapath
// stand-in with programmable result delay; directed cases then randomized traffic.
module tb_mac_scheduler;
  import mac_sched_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] req_a, req_b, req_c;
  logic [N-1:0]        gnt;
  logic                validi;
  logic [DATA_W-1:0]   data_in;
  logic                valido;
  logic [DATA_W-1:0]   data_out;
  logic [N-1:0]        rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic                spurious;

  always #5 clk = ~clk;

  mac_scheduler #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .gnt(gnt), .validi(validi), .data_in(data_in), .valido(valido), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .spurious(spurious)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // values seen by the upcoming edge
  logic                s_rst, s_valido, s_validi;
  logic [N-1:0]        s_req;
  logic [N*DATA_W-1:0] s_a, s_b, s_c;
  logic [DATA_W-1:0]   s_dout, s_din;

  // reference model: one operation in flight, described by its start edge
  bit          m_busy = 0;
  int          m_start = 0, m_owner = 0, m_ptr = 0;
  logic [7:0]  m_b, m_c;
  logic [N-1:0] e_gnt, e_rv;
  logic        e_validi, e_re, e_spur;
  logic [7:0]  e_din, e_rd;

  // datapath stand-in
  int          dp_n = 0;
  logic [7:0]  dp_w0, dp_w1;
  bit          dp_pend = 0;
  int          dp_edge = 0;
  logic [7:0]  dp_res;
  int          dp_delay = 0;
  bit          dp_rand = 0;
  bit          spur_next = 0;
  bit          spur_rand = 0;
  int          vrun = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [N*DATA_W-1:0] m;
    m = (N*DATA_W)'(8'hFF) << (idx*8);
    req_a = (req_a & ~m) | ((N*DATA_W)'(a) << (idx*8));
    req_b = (req_b & ~m) | ((N*DATA_W)'(b) << (idx*8));
    req_c = (req_c & ~m) | ((N*DATA_W)'(c) << (idx*8));
  endtask

  task automatic dp_drive();
    valido   = 1'b0;
    data_out = 8'($urandom);
    if (dp_pend && dp_edge == cyc + 1) begin
      valido   = 1'b1;
      data_out = dp_res;
      dp_pend  = 0;
    end else if (spur_next) begin
      valido    = 1'b1;
      spur_next = 0;
    end else if (spur_rand && $urandom_range(0, 19) == 0 && (!m_busy || (cyc + 1 - m_start) <= 3)) begin
      valido = 1'b1;
    end
  endtask

  task automatic model_update();
    int k;
    bit found;
    int w;
    e_gnt = '0; e_validi = 0; e_din = '0; e_rv = '0; e_rd = '0; e_re = 0; e_spur = 0;
    if (s_rst) begin
      m_busy = 0;
      m_ptr  = 0;
    end else if (m_busy) begin
      k = cyc - m_start;
      e_spur = s_valido && (k < 4);
      if (k == 1) begin
        e_validi = 1; e_din = m_b;
      end else if (k == 2) begin
        e_validi = 1; e_din = m_c;
      end else if (k >= 4) begin
        if (s_valido) begin
          e_rv = N'(1) << m_owner; e_rd = s_dout; m_busy = 0;
        end else if (k == 3 + TMO) begin
          e_rv = N'(1) << m_owner; e_re = 1; m_busy = 0;
        end
      end
    end else begin
      e_spur = s_valido;
      found = 0;
      for (int off = 0; off < N; off++) begin
        w = (m_ptr + off) % N;
        if (!found && ((s_req >> w) & N'(1)) != '0) begin
          found    = 1;
          m_busy   = 1;
          m_start  = cyc;
          m_owner  = w;
          e_gnt    = N'(1) << w;
          e_validi = 1;
          e_din    = 8'(s_a >> (w*8));
          m_b      = 8'(s_b >> (w*8));
          m_c      = 8'(s_c >> (w*8));
          m_ptr    = (w + 1) % N;
        end
      end
    end
  endtask

  task automatic compare();
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("validi", 32'(validi), 32'(e_validi));
    check("data_in", 32'(data_in), 32'(e_din));
    check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    check("rsp_err", 32'(rsp_err), 32'(e_re));
    check("spurious", 32'(spurious), 32'(e_spur));
    if (e_rv != '0) check("rsp_data", 32'(rsp_data), 32'(e_rd));
    vrun = validi ? vrun + 1 : 0;
    check("validi_run_too_long", 32'(vrun > MAC_OPS), 32'(0));
  endtask

  task automatic dp_update();
    int d;
    if (s_rst) begin
      dp_n = 0; dp_pend = 0;
    end else if (s_validi) begin
      if (dp_n == 0) begin
        dp_w0 = s_din; dp_n = 1;
      end else if (dp_n == 1) begin
        dp_w1 = s_din; dp_n = 2;
      end else begin
        dp_n   = 0;
        dp_res = 8'((int'(dp_w0) * int'(dp_w1) + int'(s_din)) % 256);
        if (dp_rand) begin
          d = $urandom_range(0, 9);
          if (d <= 5) d = d % 4;
          else if (d == 6) d = TMO - 1;
          else if (d == 7) d = TMO;
          else if (d == 8) d = TMO + 1;
          else d = -1;
        end else begin
          d = dp_delay;
        end
        if (d >= 0) begin
          dp_pend = 1; dp_edge = cyc + 1 + d;
        end
      end
    end
  endtask

  task automatic step();
    dp_drive();
    s_rst = rst; s_req = req; s_a = req_a; s_b = req_b; s_c = req_c;
    s_valido = valido; s_dout = data_out; s_validi = validi; s_din = data_in;
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    compare();
    dp_update();
  endtask

  task automatic op_directed(input string nm, input int idx, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input int delay, input logic [7:0] exp_data,
                             input bit exp_err, input int exp_lat);
    int gcyc;
    bit found;
    dp_delay = delay;
    set_ops(idx, a, b, c);
    req = N'(1) << idx;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (gnt != '0) found = 1;
    end
    if (!found) begin
      check({nm, "_no_grant"}, 32'(0), 32'(1));
    end else begin
      gcyc = cyc;
      req  = '0;
      check({nm, "_gnt"}, 32'(gnt), 32'(N'(1) << idx));
      check({nm, "_op_a"}, 32'(data_in), 32'(a));
      step();
      check({nm, "_op_b"}, 32'(data_in), 32'(b));
      step();
      check({nm, "_op_c"}, 32'(data_in), 32'(c));
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        step();
        if (rsp_valid != '0) found = 1;
      end
      if (!found) begin
        check({nm, "_no_response"}, 32'(0), 32'(1));
      end else begin
        check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(N'(1) << idx));
        check({nm, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check({nm, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({nm, "_latency"}, 32'(cyc - gcyc), 32'(exp_lat));
      end
    end
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    int gq[$];
    int gc[$];
    bit found;
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_c = '0;
    valido = 1'b0; data_out = '0;

    for (int i = 0; i < 3; i++) step();
    check("rst_validi", 32'(validi), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    rst = 1'b0;
    step();

    op_directed("mac_3_4_5", 0, 8'd3, 8'd4, 8'd5, 0, 8'd17, 1'b0, 4);
    op_directed("mac_wrap", 0, 8'd20, 8'd20, 8'd10, 0, 8'd154, 1'b0, 4);
    op_directed("mac_req2", 2, 8'd7, 8'd9, 8'd200, 1, 8'd7, 1'b0, 5);
    op_directed("timeout", 1, 8'd1, 8'd2, 8'd3, -1, 8'd0, 1'b1, 3 + TMO);
    op_directed("last_chance", 0, 8'd5, 8'd6, 8'd7, TMO - 1, 8'd37, 1'b0, 3 + TMO);
    op_directed("too_late", 1, 8'd9, 8'd9, 8'd9, TMO, 8'd0, 1'b1, 3 + TMO);

    // stray result strobe while idle
    spur_next = 1;
    step();
    check("idle_spurious", 32'(spurious), 32'(1));
    check("idle_spurious_no_rsp", 32'(rsp_valid), 32'(0));
    step();
    check("idle_spurious_clears", 32'(spurious), 32'(0));

    // two requesters held from reset alternate every five cycles
    dp_delay = 0;
    rst = 1'b1;
    set_ops(0, 8'd2, 8'd3, 8'd4);
    set_ops(1, 8'd5, 8'd6, 8'd7);
    req = 3'b011;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (gnt != '0) begin
        for (int k = 0; k < N; k++) if (gnt[k]) gq.push_back(k);
        gc.push_back(cyc);
      end
    end
    req = '0;
    if (gq.size() < 4) begin
      check("alt_grant_count", 32'(gq.size()), 32'(4));
    end else begin
      check("alt_grant0", 32'(gq[0]), 32'(0));
      check("alt_grant1", 32'(gq[1]), 32'(1));
      check("alt_grant2", 32'(gq[2]), 32'(0));
      check("alt_grant3", 32'(gq[3]), 32'(1));
      check("alt_gap1", 32'(gc[1] - gc[0]), 32'(5));
      check("alt_gap3", 32'(gc[3] - gc[2]), 32'(5));
    end
    for (int i = 0; i < 10; i++) step();

    // reset in the middle of streaming operand b
    set_ops(0, 8'd11, 8'd22, 8'd33);
    req = 3'b001;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (gnt != '0) found = 1;
    end
    if (!found) check("rst_mid_no_grant", 32'(0), 32'(1));
    req = '0;
    step();
    check("rst_mid_send_b", 32'(data_in), 32'(22));
    rst = 1'b1;
    step();
    check("rst_mid_gnt", 32'(gnt), 32'(0));
    check("rst_mid_validi", 32'(validi), 32'(0));
    check("rst_mid_data_in", 32'(data_in), 32'(0));
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_mid_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_mid_rsp_err", 32'(rsp_err), 32'(0));
    check("rst_mid_spurious", 32'(spurious), 32'(0));
    rst = 1'b0;
    set_ops(1, 8'd1, 8'd1, 8'd1);
    req = 3'b011;
    step();
    check("rst_ptr_restart", 32'(gnt), 32'(3'b001));
    req = '0;
    for (int i = 0; i < 12; i++) step();

    // randomized traffic, result delays, stray strobes and occasional reset
    dp_rand   = 1;
    spur_rand = 1;
    for (int t = 0; t < 1500; t++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (gnt[i] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0)) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_ops(i, 8'($urandom), 8'($urandom), 8'($urandom));
          req[i] = 1'b1;
        end
      end
      step();
    end
    rst = 1'b0;
    req = '0;
    spur_rand = 0;
    for (int i = 0; i < 15; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
